// File: rtl/aes_bridge_pkg.sv
// ---------------------------------------------------------------------------
// aes_bridge_pkg
// Shared types and default sizes for the AES memory bridge.
//   bridge_state_e : LOAD / RUN / DRAIN controller states
//   DEF_DW         : default data width (bits)
//   DEF_DEPTH      : default block size (bytes, power of two)
//   DEF_TIMEOUT    : default watchdog limit (RUN cycles)
// ---------------------------------------------------------------------------
package aes_bridge_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/aes_bridge_regfile.sv
// ---------------------------------------------------------------------------
// aes_bridge_regfile
// DEPTH x DW flop array holding one block. Not reset: contents are only
// meaningful after a full load.
// Ports:
//   clk          : clock
//   we           : write enable
//   waddr/wdata  : single write port (source muxed by the parent)
//   raddr_core   : combinational read address for the core port
//   rdata_core   : combinational read data for the core port
//   raddr_drain  : combinational read address for the output stream
//   rdata_drain  : combinational read data for the output stream
// ---------------------------------------------------------------------------
module aes_bridge_regfile
  import aes_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_core,
  output logic [DW-1:0] rdata_core,
  input  logic [AW-1:0] raddr_drain,
  output logic [DW-1:0] rdata_drain
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_core  = mem[raddr_core];
  assign rdata_drain = mem[raddr_drain];

endmodule

// File: rtl/aes_mem_bridge.sv
// ---------------------------------------------------------------------------
// aes_mem_bridge
// Loads a block from a byte stream, hands it to the HLS AES core through an
// ap_memory port, then streams the in-place result out. A watchdog ends the
// run if the core never signals completion.
// Ports:
//   ap_clk, ap_rst_n          : clock, async active-low reset
//   s_data/s_valid/s_ready    : input byte stream (ready only in LOAD)
//   m_data/m_valid/m_ready    : output byte stream (valid only in DRAIN)
//   ap_start/ap_done          : core handshake (ap_ctrl_hs)
//   data_address0/ce0/we0/d0  : core memory request
//   data_q0                   : core read data, one-cycle latency
//   timeout                   : sticky watchdog-abort flag
//
// state | meaning
// ------+---------------------------------------------
// LOAD  | accept input bytes into the buffer
// RUN   | core owns the buffer, ap_start high
// DRAIN | stream buffer contents to the output port
// ---------------------------------------------------------------------------
module aes_mem_bridge
  import aes_bridge_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DW      = DEF_DW,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          ap_start,
  input  logic          ap_done,
  input  logic [AW-1:0] data_address0,
  input  logic          data_ce0,
  input  logic          data_we0,
  input  logic [DW-1:0] data_d0,
  output logic [DW-1:0] data_q0,
  output logic          timeout
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;

  logic [AW-1:0] wp, rp;
  logic [WW-1:0] wdog;

  logic          load_acc;
  logic          drain_acc;
  logic          core_rd;
  logic          wdog_exp;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rd_core;
  logic [DW-1:0] rd_drain;

  assign wdog_exp = (wdog == WDOG_LAST);

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ap_done takes priority over watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (s_valid && (wp == LAST_ADDR)) state_d = RUN;
      end
      RUN: begin
        if (ap_done || wdog_exp) state_d = DRAIN;
      end
      DRAIN: begin
        if (m_ready && (rp == LAST_ADDR)) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    ap_start  = 1'b0;
    load_acc  = 1'b0;
    drain_acc = 1'b0;
    core_rd   = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = wp;
    rf_wdata  = s_data;
    case (state_q)
      LOAD: begin
        s_ready  = 1'b1;
        load_acc = s_valid;
        rf_we    = s_valid;
      end
      RUN: begin
        ap_start = 1'b1;
        core_rd  = data_ce0 && !data_we0;
        rf_we    = data_ce0 && data_we0;
        rf_waddr = data_address0;
        rf_wdata = data_d0;
      end
      DRAIN: begin
        m_valid   = 1'b1;
        drain_acc = m_ready;
      end
      default: ;
    endcase
  end

  // Pointers, watchdog, registered core read data, sticky abort flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wp      <= '0;
      rp      <= '0;
      wdog    <= '0;
      data_q0 <= '0;
      timeout <= 1'b0;
    end else begin
      // wp/rp wrap to zero after the last byte since DEPTH is a power of two
      if (load_acc)  wp <= wp + AW'(1);
      if (drain_acc) rp <= rp + AW'(1);

      // Held at zero outside RUN, so it is already clear on entry to RUN
      if (state_q == RUN) wdog <= wdog + WW'(1);
      else                wdog <= '0;

      if (core_rd) data_q0 <= rd_core;

      if ((state_q == RUN) && wdog_exp && !ap_done) timeout <= 1'b1;
    end
  end

  assign m_data = rd_drain;

  aes_bridge_regfile #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_regfile (
    .clk         (ap_clk),
    .we          (rf_we),
    .waddr       (rf_waddr),
    .wdata       (rf_wdata),
    .raddr_core  (data_address0),
    .rdata_core  (rd_core),
    .raddr_drain (rp),
    .rdata_drain (rd_drain)
  );

endmodule

// File: tb/tb_aes_mem_bridge.sv
module tb_aes_mem_bridge;

  localparam int DEPTH   = 16;
  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;

  logic          ap_clk;
  logic          ap_rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          ap_start;
  logic          ap_done;
  logic [AW-1:0] data_address0;
  logic          data_ce0;
  logic          data_we0;
  logic [DW-1:0] data_d0;
  logic [DW-1:0] data_q0;
  logic          timeout;

  aes_mem_bridge #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .data_address0 (data_address0),
    .data_ce0      (data_ce0),
    .data_we0      (data_we0),
    .data_d0       (data_d0),
    .data_q0       (data_q0),
    .timeout       (timeout)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q0;
  } core_vec_t;

  core_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic load_block(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      mdl[i]  = base + DW'(i);
      check("load_ready", {31'b0, s_ready}, 32'd1);
      if (i == DEPTH - 1) check("start_before_last", {31'b0, ap_start}, 32'd0);
      tick();
    end
    s_valid = 1'b0;
    check("start_rise", {31'b0, ap_start}, 32'd1);
    check("ready_drop", {31'b0, s_ready}, 32'd0);
  endtask

  task automatic push_model();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mdl[i]);
  endtask

  // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0 repeating
  task automatic drain(input int mode);
    int cyc = 0;
    int k = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] e;
    while (exp_q.size() > 0 && cyc < 200) begin
      m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      k++;
      if (m_valid && stalled) check("stall_hold", {24'b0, m_data}, {24'b0, held});
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        check("drain_data", {24'b0, m_data}, {24'b0, e});
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_bound: %0d bytes not emitted, required 0", exp_q.size());
      exp_q.delete();
    end
    check("turnaround_ready", {31'b0, s_ready}, 32'd1);
    check("turnaround_valid", {31'b0, m_valid}, 32'd0);
  endtask

  task automatic core_write_all(input logic [DW-1:0] base, input bit done_on_last);
    for (int a = 0; a < DEPTH; a++) begin
      data_ce0      = 1'b1;
      data_we0      = 1'b1;
      data_address0 = AW'(a);
      data_d0       = base + DW'(a);
      mdl[a]        = base + DW'(a);
      if (done_on_last && a == DEPTH - 1) begin
        ap_done = 1'b1;
        check("start_in_done_cycle", {31'b0, ap_start}, 32'd1);
      end
      tick();
    end
    data_ce0 = 1'b0;
    data_we0 = 1'b0;
    ap_done  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    vecs[0] = '{we: 1'b0, addr: 4'd5,  d: 8'h00, exp_q0: 8'h05};
    vecs[1] = '{we: 1'b0, addr: 4'd0,  d: 8'h00, exp_q0: 8'h00};
    vecs[2] = '{we: 1'b0, addr: 4'd15, d: 8'h00, exp_q0: 8'h0F};
    vecs[3] = '{we: 1'b1, addr: 4'd3,  d: 8'h77, exp_q0: 8'h00};
    vecs[4] = '{we: 1'b0, addr: 4'd3,  d: 8'h00, exp_q0: 8'h77};
    vecs[5] = '{we: 1'b1, addr: 4'd15, d: 8'h5A, exp_q0: 8'h00};
    vecs[6] = '{we: 1'b0, addr: 4'd15, d: 8'h00, exp_q0: 8'h5A};

    ap_rst_n = 1'b1;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0; ap_done = 1'b0;
    data_address0 = '0; data_ce0 = 1'b0; data_we0 = 1'b0; data_d0 = '0;
    #2 ap_rst_n = 1'b0;
    #1;
    check("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_ap_start", {31'b0, ap_start}, 32'd0);
    check("rst_data_q0", {24'b0, data_q0}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();

    // Block 1: load 0x00..0x0F, table of core accesses, full rewrite, drain
    load_block(8'h00);
    for (int v = 0; v < 7; v++) begin
      data_ce0      = 1'b1;
      data_we0      = vecs[v].we;
      data_address0 = vecs[v].addr;
      data_d0       = vecs[v].d;
      if (vecs[v].we) mdl[vecs[v].addr] = vecs[v].d;
      tick();
      data_ce0 = 1'b0;
      data_we0 = 1'b0;
      if (!vecs[v].we) check($sformatf("core_read_%0d", v), {24'b0, data_q0}, {24'b0, vecs[v].exp_q0});
    end
    data_address0 = 4'd1;
    tick();
    check("q0_hold", {24'b0, data_q0}, 32'h5A);

    core_write_all(8'hA0, 1'b1);
    check("done_m_valid", {31'b0, m_valid}, 32'd1);
    check("done_ap_start", {31'b0, ap_start}, 32'd0);
    check("done_timeout", {31'b0, timeout}, 32'd0);
    push_model();
    // core-side writes outside RUN must be ignored
    data_ce0 = 1'b1; data_we0 = 1'b1; data_address0 = 4'd0; data_d0 = 8'hFF;
    drain(0);
    data_ce0 = 1'b0; data_we0 = 1'b0;

    // Block 2: stalled drain with m_ready 1,0,0,...
    load_block(8'h10);
    core_write_all(8'hB0, 1'b1);
    push_model();
    drain(1);

    // Block 3: ap_done on the last allowed RUN cycle -> normal completion
    load_block(8'h20);
    repeat (TIMEOUT - 1) tick();
    ap_done = 1'b1;
    check("late_done_pre_valid", {31'b0, m_valid}, 32'd0);
    tick();
    ap_done = 1'b0;
    check("late_done_valid", {31'b0, m_valid}, 32'd1);
    check("late_done_timeout", {31'b0, timeout}, 32'd0);
    push_model();
    drain(0);

    // Block 4: core never finishes; partial rewrite then watchdog abort
    load_block(8'h30);
    cnt = 0;
    for (int a = 0; a < 8; a++) begin
      data_ce0 = 1'b1; data_we0 = 1'b1;
      data_address0 = AW'(a); data_d0 = 8'hC0 + DW'(a);
      mdl[a] = 8'hC0 + DW'(a);
      tick();
      cnt++;
    end
    data_ce0 = 1'b0; data_we0 = 1'b0;
    while (!m_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    check("wdog_cycles", cnt, TIMEOUT);
    check("wdog_timeout", {31'b0, timeout}, 32'd1);
    check("wdog_ap_start", {31'b0, ap_start}, 32'd0);
    push_model();
    drain(0);
    check("timeout_sticky", {31'b0, timeout}, 32'd1);

    // Block 5: reset in the middle of RUN, then a fresh block
    load_block(8'h40);
    data_ce0 = 1'b1; data_we0 = 1'b0; data_address0 = 4'd1;
    tick();
    data_ce0 = 1'b0;
    check("pre_rst_q0", {24'b0, data_q0}, 32'h41);
    #3 ap_rst_n = 1'b0;
    #1;
    check("arst_ap_start", {31'b0, ap_start}, 32'd0);
    check("arst_s_ready", {31'b0, s_ready}, 32'd1);
    check("arst_m_valid", {31'b0, m_valid}, 32'd0);
    check("arst_data_q0", {24'b0, data_q0}, 32'd0);
    check("arst_timeout", {31'b0, timeout}, 32'd0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    load_block(8'h50);
    data_ce0 = 1'b1; data_we0 = 1'b0; data_address0 = 4'd5;
    tick();
    data_ce0 = 1'b0;
    check("post_rst_read", {24'b0, data_q0}, 32'h55);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("post_rst_valid", {31'b0, m_valid}, 32'd1);
    push_model();
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
